// File: rtl/decode_pkg.sv
// Shared decode types: ALU op codes, opcode/funct7 constants, the decoded control
// bundle and immediate builders. Used by decode_comb and decode_stage.
package decode_pkg;

    localparam int PC_W      = 64;
    localparam int MAX_DEPTH = 4;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_MUL  = 4'd9,
        ALU_MULH = 4'd10,
        ALU_DIV  = 4'd11,
        ALU_REM  = 4'd12
    } aluop_t;

    // imm keeps the 32-bit form; every immediate is sign-extended from bit 31,
    // so consumers widen it to their own XLEN. pc is sized for the widest core.
    typedef struct packed {
        logic            mem_write;
        logic            reg_write;
        logic            alu_src;
        logic            mem_to_reg;
        logic            branch;
        aluop_t          alu_op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
        logic [PC_W-1:0] pc;
        logic            illegal;
    } ctrl_t;

    function automatic logic [31:0] imm_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational instruction decoder (instr -> ctrl_t), shared with the single-cycle core.
// Define DECODE_MULDIV_EN to accept the MUL/MULH/DIV/REM encodings; otherwise they are illegal.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output ctrl_t           ctrl_o
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       legal;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        ctrl_o        = '0;
        legal         = 1'b0;
        ctrl_o.rd     = instr_i[11:7];
        ctrl_o.rs1    = instr_i[19:15];
        ctrl_o.rs2    = instr_i[24:20];
        ctrl_o.pc     = PC_W'(pc_i);
        ctrl_o.alu_op = ALU_ADD;
        case (opcode)
            OPC_LOAD: begin
                legal             = (funct3 == 3'b010);
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.imm        = imm_i(instr_i);
            end
            OPC_STORE: begin
                legal            = (funct3 == 3'b010);
                ctrl_o.mem_write = 1'b1;
                ctrl_o.imm       = imm_s(instr_i);
            end
            OPC_OP: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000:  ctrl_o.alu_op = ALU_ADD;
                        3'b001:  ctrl_o.alu_op = ALU_SLL;
                        3'b010:  ctrl_o.alu_op = ALU_SLT;
                        3'b100:  ctrl_o.alu_op = ALU_XOR;
                        3'b101:  ctrl_o.alu_op = ALU_SRL;
                        3'b110:  ctrl_o.alu_op = ALU_OR;
                        3'b111:  ctrl_o.alu_op = ALU_AND;
                        default: legal = 1'b0;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000:  ctrl_o.alu_op = ALU_SUB;
                        3'b101:  ctrl_o.alu_op = ALU_SRA;
                        default: legal = 1'b0;
                    endcase
                end
`ifdef DECODE_MULDIV_EN
                else if (funct7 == F7_MULDIV) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000:  ctrl_o.alu_op = ALU_MUL;
                        3'b001:  ctrl_o.alu_op = ALU_MULH;
                        3'b100:  ctrl_o.alu_op = ALU_DIV;
                        3'b110:  ctrl_o.alu_op = ALU_REM;
                        default: legal = 1'b0;
                    endcase
                end
`endif
            end
            OPC_OPIMM: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.imm       = imm_i(instr_i);
                legal            = 1'b1;
                case (funct3)
                    3'b000: ctrl_o.alu_op = ALU_ADD;
                    3'b010: ctrl_o.alu_op = ALU_SLT;
                    3'b100: ctrl_o.alu_op = ALU_XOR;
                    3'b110: ctrl_o.alu_op = ALU_OR;
                    3'b111: ctrl_o.alu_op = ALU_AND;
                    3'b001: begin
                        ctrl_o.alu_op = ALU_SLL;
                        legal         = (funct7 == F7_BASE);
                    end
                    3'b101: begin
                        ctrl_o.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                        legal         = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                ctrl_o.branch  = 1'b1;
                ctrl_o.alu_src = 1'b1;
                ctrl_o.imm     = imm_b(instr_i);
                case (funct3)
                    3'b000, 3'b001: begin
                        ctrl_o.alu_op = ALU_SUB;
                        legal         = 1'b1;
                    end
                    3'b100, 3'b101: begin
                        ctrl_o.alu_op = ALU_SLT;
                        legal         = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        // Unsupported encodings still flow downstream, but with every side effect masked.
        if (!legal) begin
            ctrl_o.mem_write  = 1'b0;
            ctrl_o.reg_write  = 1'b0;
            ctrl_o.mem_to_reg = 1'b0;
            ctrl_o.branch     = 1'b0;
            ctrl_o.alu_src    = 1'b0;
            ctrl_o.alu_op     = ALU_ADD;
            ctrl_o.imm        = '0;
            ctrl_o.illegal    = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decode_comb feeding a small output FIFO with valid/ready on both sides.
// Optional DECODE_MULDIV_EN (see decode_comb) enables the multiply/divide encodings.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inValid,
    output logic            inReady,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pcIn,
    input  logic            flush,
    output logic            outValid,
    input  logic            outReady,
    output logic            memWrite,
    output logic            regWrite,
    output logic            aluSrc,
    output logic            memToReg,
    output logic            branch,
    output logic [3:0]      aluOp,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] pcOut,
    output logic            illegal
);

    localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);
    localparam logic [1:0] LAST  = 2'(BUF_DEPTH - 1);

    ctrl_t      dec;
    ctrl_t      mem_q [MAX_DEPTH];
    logic [1:0] wptr_q, wptr_d;
    logic [1:0] rptr_q, rptr_d;
    logic [2:0] count_q, count_d;
    logic       push, pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    decode_comb #(.XLEN(XLEN)) u_decode_comb (
        .instr_i (instr),
        .pc_i    (pcIn),
        .ctrl_o  (dec)
    );

    // Ready depends on the registered count only, so outReady never reaches inReady.
    assign inReady  = (count_q < DEPTH);
    assign outValid = (count_q != 3'd0);
    assign push     = inValid && inReady && !flush;
    assign pop      = outValid && outReady && !flush;

    always_comb begin
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (flush) begin
            count_d = 3'd0;
            wptr_d  = 2'd0;
            rptr_d  = 2'd0;
        end else begin
            if (push) wptr_d = ptr_inc(wptr_q);
            if (pop)  rptr_d = ptr_inc(rptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 3'd0;
            wptr_q  <= 2'd0;
            rptr_q  <= 2'd0;
            for (int i = 0; i < MAX_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            if (push) mem_q[wptr_q] <= dec;
        end
    end

    assign memWrite = mem_q[rptr_q].mem_write;
    assign regWrite = mem_q[rptr_q].reg_write;
    assign aluSrc   = mem_q[rptr_q].alu_src;
    assign memToReg = mem_q[rptr_q].mem_to_reg;
    assign branch   = mem_q[rptr_q].branch;
    assign aluOp    = mem_q[rptr_q].alu_op;
    assign rd       = mem_q[rptr_q].rd;
    assign rs1      = mem_q[rptr_q].rs1;
    assign rs2      = mem_q[rptr_q].rs2;
    assign imm      = XLEN'($signed(mem_q[rptr_q].imm));
    assign pcOut    = mem_q[rptr_q].pc[XLEN-1:0];
    assign illegal  = mem_q[rptr_q].illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (default parameters): handshake, ordering, backpressure,
// flush, illegal encodings and asynchronous reset, with hand-computed expectations.
module tb_decode_stage;

    localparam int XLEN = 32;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic            inValid  = 1'b0;
    logic            flush    = 1'b0;
    logic            outReady = 1'b0;
    logic [31:0]     instr    = '0;
    logic [XLEN-1:0] pcIn     = '0;
    logic            inReady, outValid;
    logic            memWrite, regWrite, aluSrc, memToReg, branch, illegal;
    logic [3:0]      aluOp;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] imm, pcOut;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .BUF_DEPTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inValid  (inValid),
        .inReady  (inReady),
        .instr    (instr),
        .pcIn     (pcIn),
        .flush    (flush),
        .outValid (outValid),
        .outReady (outReady),
        .memWrite (memWrite),
        .regWrite (regWrite),
        .aluSrc   (aluSrc),
        .memToReg (memToReg),
        .branch   (branch),
        .aluOp    (aluOp),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .imm      (imm),
        .pcOut    (pcOut),
        .illegal  (illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
        inValid = 1'b1;
        instr   = ins;
        pcIn    = pc;
    endtask

    // ctl = {memWrite, regWrite, aluSrc, memToReg, branch}
    task automatic head(input string t, input logic [4:0] ctl, input logic [3:0] op,
                        input logic [4:0] erd, input logic [31:0] eimm, input logic [31:0] epc);
        chk({t, ".vld"}, outValid, 1);
        chk({t, ".ctl"}, {memWrite, regWrite, aluSrc, memToReg, branch}, ctl);
        chk({t, ".op"},  aluOp, op);
        chk({t, ".rd"},  rd, erd);
        chk({t, ".imm"}, imm, eimm);
        chk({t, ".pc"},  pcOut, epc);
        chk({t, ".ill"}, illegal, 0);
    endtask

    initial begin
        repeat (2) tick();
        chk("rst.vld", outValid, 0);
        chk("rst.rdy", inReady, 1);
        chk("rst.pc",  pcOut, 0);
        chk("rst.imm", imm, 0);
        chk("rst.ctl", {memWrite, regWrite, aluSrc, memToReg, branch, illegal}, 0);
        chk("rst.op",  aluOp, 0);
        rst_n    = 1'b1;
        outReady = 1'b1;

        // lw x5,8(x1)
        offer(32'h0080A283, 32'h100);
        chk("lw.rdy", inReady, 1);
        tick();
        inValid = 1'b0;
        head("lw", 5'b01010, 4'd0, 5'd5, 32'd8, 32'h100);
        chk("lw.rs1", rs1, 1);
        tick();
        chk("lw.pop", outValid, 0);

        // sw x2,12(x1) then sub x3,x1,x2 back to back
        offer(32'h0020A623, 32'h200);
        tick();
        offer(32'h402081B3, 32'h204);
        head("sw", 5'b10000, 4'd0, 5'd12, 32'd12, 32'h200);
        chk("sw.rs2", rs2, 2);
        tick();
        inValid = 1'b0;
        head("sub", 5'b01100, 4'd1, 5'd3, 32'd0, 32'h204);
        tick();
        chk("sub.pop", outValid, 0);

        // Backpressure: addi x1,x0,-1 ; blt x1,x2,+16 ; ori x4,x0,5
        outReady = 1'b0;
        offer(32'hFFF00093, 32'h300);
        tick();
        offer(32'h0020C863, 32'h304);
        tick();
        offer(32'h00506213, 32'h308);
        chk("bp.full", inReady, 0);
        head("addi", 5'b01000, 4'd0, 5'd1, 32'hFFFFFFFF, 32'h300);
        tick();
        chk("bp.hold", inReady, 0);
        chk("bp.hold_pc", pcOut, 32'h300);
        outReady = 1'b1;
        chk("bp.popfull", inReady, 0);
        tick();
        outReady = 1'b0;
        chk("bp.reopen", inReady, 1);
        head("blt", 5'b00101, 4'd5, 5'd16, 32'd16, 32'h304);
        tick();
        inValid = 1'b0;
        chk("bp.refull", inReady, 0);
        chk("bp.keep_pc", pcOut, 32'h304);
        outReady = 1'b1;
        tick();
        head("ori", 5'b01000, 4'd3, 5'd4, 32'd5, 32'h308);
        tick();
        chk("bp.drain", outValid, 0);

        // srai x1,x1,3
        offer(32'h4030D093, 32'h40C);
        tick();
        inValid = 1'b0;
        head("srai", 5'b01000, 4'd8, 5'd1, 32'h403, 32'h40C);
        tick();

        // Flush with two entries buffered plus an offered instruction
        outReady = 1'b0;
        offer(32'h0080A283, 32'h500);
        tick();
        offer(32'h0020A623, 32'h504);
        tick();
        flush = 1'b1;
        offer(32'h402081B3, 32'h508);
        chk("fl.pre", outValid, 1);
        tick();
        flush   = 1'b0;
        inValid = 1'b0;
        chk("fl.empty", outValid, 0);
        chk("fl.rdy", inReady, 1);
        tick();
        chk("fl.drop", outValid, 0);

        // Flush with one entry: the offered instruction sees inReady=1 but is dropped
        offer(32'h0080A283, 32'h600);
        tick();
        flush = 1'b1;
        offer(32'h402081B3, 32'h604);
        chk("fl1.rdy", inReady, 1);
        tick();
        flush   = 1'b0;
        inValid = 1'b0;
        chk("fl1.empty", outValid, 0);
        tick();
        chk("fl1.drop", outValid, 0);
        offer(32'h402081B3, 32'h700);
        tick();
        inValid = 1'b0;
        head("postfl", 5'b01100, 4'd1, 5'd3, 32'd0, 32'h700);
        outReady = 1'b1;
        tick();
        chk("postfl.pop", outValid, 0);

        // mul x3,x1,x2
        offer(32'h022081B3, 32'h800);
        tick();
        inValid = 1'b0;
`ifdef DECODE_MULDIV_EN
        head("mul", 5'b01100, 4'd9, 5'd3, 32'd0, 32'h800);
`else
        chk("mul.vld", outValid, 1);
        chk("mul.ill", illegal, 1);
        chk("mul.side", {memWrite, regWrite, memToReg, branch}, 0);
        chk("mul.pc", pcOut, 32'h800);
`endif
        tick();

        // All-ones word is illegal in every build and still delivered
        offer(32'hFFFFFFFF, 32'h804);
        tick();
        inValid = 1'b0;
        chk("ones.vld", outValid, 1);
        chk("ones.ill", illegal, 1);
        chk("ones.side", {memWrite, regWrite, memToReg, branch}, 0);
        chk("ones.pc", pcOut, 32'h804);
        tick();
        chk("ones.pop", outValid, 0);

        // Asynchronous reset with two entries buffered
        outReady = 1'b0;
        offer(32'h0080A283, 32'h900);
        tick();
        offer(32'h402081B3, 32'h904);
        tick();
        inValid = 1'b0;
        chk("rs.pre", inReady, 0);
        rst_n = 1'b0;
        #1;
        chk("rs.vld", outValid, 0);
        chk("rs.rdy", inReady, 1);
        chk("rs.pc",  pcOut, 0);
        chk("rs.rd",  rd, 0);
        chk("rs.imm", imm, 0);
        chk("rs.ctl", {memWrite, regWrite, aluSrc, memToReg, branch, illegal}, 0);
        chk("rs.op",  aluOp, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rs.post", outValid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
